// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters and Execute-stage mispredict detection.
// Optional statistics counters are compiled in with `define BPRED_STATS_EN.
module branch_predictor #(
  parameter int PC_WIDTH   = 32,
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = PC_WIDTH - INDEX_BITS - 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [PC_WIDTH-1:0] PCF_i,
  output logic                predictTakenF_o,
  output logic [PC_WIDTH-1:0] predictTargetF_o,
  input  logic                BranchE_i,
  input  logic                JumpE_i,
  input  logic                isJalrE_i,
  input  logic                takenE_i,
  input  logic                predictTakenE_i,
  input  logic [PC_WIDTH-1:0] PCE_i,
  input  logic [PC_WIDTH-1:0] PCTargetE_i,
  input  logic [PC_WIDTH-1:0] PCPlus4E_i,
  input  logic                stallE_i,
  output logic                mispredictE_o,
  output logic [PC_WIDTH-1:0] recoverPCE_o,
  output logic [31:0]         branchCount_o,
  output logic [31:0]         mispredictCount_o
);

  localparam int unsigned ENTRIES = 2 ** INDEX_BITS;

  logic                valid_q  [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [PC_WIDTH-1:0] target_q [ENTRIES];

  logic [INDEX_BITS-1:0] idxF, idxE;
  logic [TAG_BITS-1:0]   tagF, tagE;
  logic                  hitF, hitE;
  logic                  activeE, updateE;

  logic                ent_we;
  logic                ent_valid_d;
  logic [1:0]          ent_ctr_d;
  logic [PC_WIDTH-1:0] ent_target_d;

  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{PCF_i[1:0], PCE_i[1:0]};

  assign idxF = PCF_i[INDEX_BITS+1:2];
  assign tagF = PCF_i[PC_WIDTH-1:INDEX_BITS+2];
  assign idxE = PCE_i[INDEX_BITS+1:2];
  assign tagE = PCE_i[PC_WIDTH-1:INDEX_BITS+2];

  assign hitF = valid_q[idxF] && (tag_q[idxF] == tagF);
  assign hitE = valid_q[idxE] && (tag_q[idxE] == tagE);

  assign predictTakenF_o  = hitF && ctr_q[idxF][1];
  assign predictTargetF_o = predictTakenF_o ? target_q[idxF] : '0;

  assign activeE = BranchE_i | JumpE_i;
  assign updateE = activeE && !stallE_i;

  always_comb begin
    mispredictE_o = (activeE && (predictTakenE_i != takenE_i))
                 || (isJalrE_i && JumpE_i)
                 || (!activeE && predictTakenE_i);
    recoverPCE_o  = '0;
    if (mispredictE_o)
      recoverPCE_o = (activeE && takenE_i) ? PCTargetE_i : PCPlus4E_i;
  end

  always_comb begin
    ent_we       = 1'b0;
    ent_valid_d  = valid_q[idxE];
    ent_ctr_d    = ctr_q[idxE];
    ent_target_d = target_q[idxE];
    if (updateE) begin
      if (JumpE_i && isJalrE_i) begin
        if (hitE) begin
          ent_we      = 1'b1;
          ent_valid_d = 1'b0;
        end
      end else if (JumpE_i) begin
        ent_we       = 1'b1;
        ent_valid_d  = 1'b1;
        ent_ctr_d    = 2'b11;
        ent_target_d = PCTargetE_i;
      end else if (hitE) begin
        ent_we       = 1'b1;
        ent_valid_d  = 1'b1;
        ent_target_d = PCTargetE_i;
        if (takenE_i && ctr_q[idxE] != 2'b11)
          ent_ctr_d = ctr_q[idxE] + 2'b01;
        else if (!takenE_i && ctr_q[idxE] != 2'b00)
          ent_ctr_d = ctr_q[idxE] - 2'b01;
      end else if (takenE_i) begin
        ent_we       = 1'b1;
        ent_valid_d  = 1'b1;
        ent_ctr_d    = 2'b10;
        ent_target_d = PCTargetE_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (ent_we) begin
      valid_q[idxE] <= ent_valid_d;
      ctr_q[idxE]   <= ent_ctr_d;
    end
  end

  // Tag and target carry no reset; valid gates every use of them.
  always_ff @(posedge clk_i) begin
    if (ent_we && !rst_i) begin
      tag_q[idxE]    <= tagE;
      target_q[idxE] <= ent_target_d;
    end
  end

`ifdef BPRED_STATS_EN
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  always_comb begin
    branch_cnt_d  = branch_cnt_q + (updateE ? 32'd1 : 32'd0);
    mispred_cnt_d = mispred_cnt_q + ((mispredictE_o && !stallE_i) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branchCount_o     = branch_cnt_q;
  assign mispredictCount_o = mispred_cnt_q;
`else
  assign branchCount_o     = '0;
  assign mispredictCount_o = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (BTB training, mispredict, aliasing, stall, reset).
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] PCF_i;
  logic        predictTakenF_o;
  logic [31:0] predictTargetF_o;
  logic        BranchE_i, JumpE_i, isJalrE_i, takenE_i, predictTakenE_i;
  logic [31:0] PCE_i, PCTargetE_i, PCPlus4E_i;
  logic        stallE_i;
  logic        mispredictE_o;
  logic [31:0] recoverPCE_o;
  logic [31:0] branchCount_o, mispredictCount_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_bc = '0;
  logic [31:0] exp_mc = '0;

  always #5 clk = ~clk;

  branch_predictor #(.PC_WIDTH(32), .INDEX_BITS(6)) dut (
    .clk_i(clk), .rst_i(rst_i), .PCF_i(PCF_i),
    .predictTakenF_o(predictTakenF_o), .predictTargetF_o(predictTargetF_o),
    .BranchE_i(BranchE_i), .JumpE_i(JumpE_i), .isJalrE_i(isJalrE_i),
    .takenE_i(takenE_i), .predictTakenE_i(predictTakenE_i), .PCE_i(PCE_i),
    .PCTargetE_i(PCTargetE_i), .PCPlus4E_i(PCPlus4E_i), .stallE_i(stallE_i),
    .mispredictE_o(mispredictE_o), .recoverPCE_o(recoverPCE_o),
    .branchCount_o(branchCount_o), .mispredictCount_o(mispredictCount_o)
  );

  task automatic idle_e();
    BranchE_i = 0; JumpE_i = 0; isJalrE_i = 0; takenE_i = 0; predictTakenE_i = 0;
    PCE_i = '0; PCTargetE_i = '0; PCPlus4E_i = '0; stallE_i = 0;
  endtask

  task automatic set_e(input logic br, input logic jmp, input logic jalr, input logic tk,
                       input logic pt, input logic [31:0] pc, input logic [31:0] tgt);
    BranchE_i = br; JumpE_i = jmp; isJalrE_i = jalr; takenE_i = tk; predictTakenE_i = pt;
    PCE_i = pc; PCTargetE_i = tgt; PCPlus4E_i = pc + 32'd4;
  endtask

  // Advances one clock; keeps the expected statistics from the inputs held across the edge.
  task automatic tick();
    logic act, mis;
    act = BranchE_i | JumpE_i;
    mis = (act && (predictTakenE_i != takenE_i)) || (isJalrE_i && JumpE_i) || (!act && predictTakenE_i);
    @(posedge clk);
    if (rst_i) begin
      exp_bc = '0; exp_mc = '0;
    end else if (!stallE_i) begin
      if (act) exp_bc = exp_bc + 32'd1;
      if (mis) exp_mc = exp_mc + 32'd1;
    end
    #1;
  endtask

  task automatic lookup(input logic [31:0] pc);
    PCF_i = pc;
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1; idle_e();
    PCF_i = 32'h100;
    tick(); tick();
    rst_i = 0;
    lookup(32'h100);
    checks++;
    if (predictTakenF_o !== 1'b0) begin errors++; $display("FAIL reset_pred got %0b exp 0", predictTakenF_o); end
    checks++;
    if (predictTargetF_o !== 32'h0) begin errors++; $display("FAIL reset_target got %h exp 0", predictTargetF_o); end
    checks++;
`ifdef BPRED_STATS_EN
    if (branchCount_o !== 32'd0 || mispredictCount_o !== 32'd0) begin
`else
    if (branchCount_o !== 32'd0 || mispredictCount_o !== 32'd0) begin
`endif
      errors++;
      $display("FAIL reset_counts got %0d/%0d exp 0/0", branchCount_o, mispredictCount_o);
    end
  endtask

  task automatic test_branch_training();
    lookup(32'h100);
    set_e(1, 0, 0, 1, 0, 32'h100, 32'h80);
    #1;
    checks++;
    if (mispredictE_o !== 1'b1 || recoverPCE_o !== 32'h80) begin
      errors++; $display("FAIL train_first_mis got %0b/%h exp 1/00000080", mispredictE_o, recoverPCE_o);
    end
    tick(); idle_e(); #1;
    checks++;
    if (predictTakenF_o !== 1'b1 || predictTargetF_o !== 32'h80) begin
      errors++; $display("FAIL train_taken got %0b/%h exp 1/00000080", predictTakenF_o, predictTargetF_o);
    end
    for (int i = 0; i < 2; i++) begin
      set_e(1, 0, 0, 0, 1, 32'h100, 32'h80);
      #1;
      checks++;
      if (mispredictE_o !== 1'b1 || recoverPCE_o !== 32'h104) begin
        errors++; $display("FAIL train_nt_mis%0d got %0b/%h exp 1/00000104", i, mispredictE_o, recoverPCE_o);
      end
      tick(); idle_e(); #1;
      checks++;
      if (predictTakenF_o !== 1'b0 || predictTargetF_o !== 32'h0) begin
        errors++; $display("FAIL train_nt%0d got %0b/%h exp 0/0", i, predictTakenF_o, predictTargetF_o);
      end
    end
    for (int i = 0; i < 3; i++) begin
      set_e(1, 0, 0, 0, 0, 32'h100, 32'h80);
      tick();
    end
    idle_e(); #1;
    checks++;
    if (predictTakenF_o !== 1'b0) begin errors++; $display("FAIL train_sat_pred got %0b exp 0", predictTakenF_o); end
    // From 00 one taken reaches 01 (still not taken); a second reaches 10.
    set_e(1, 0, 0, 1, 0, 32'h100, 32'h80); tick(); idle_e(); #1;
    checks++;
    if (predictTakenF_o !== 1'b0) begin errors++; $display("FAIL train_sat_up1 got %0b exp 0", predictTakenF_o); end
    set_e(1, 0, 0, 1, 0, 32'h100, 32'h80); tick(); idle_e(); #1;
    checks++;
    if (predictTakenF_o !== 1'b1 || predictTargetF_o !== 32'h80) begin
      errors++; $display("FAIL train_sat_up2 got %0b/%h exp 1/00000080", predictTakenF_o, predictTargetF_o);
    end
  endtask

  typedef struct {
    logic br, jmp, jalr, tk, pt;
    logic [31:0] pc, tgt;
    logic mis;
    logic [31:0] rec;
  } mis_vec_t;

  task automatic test_mispredict();
    mis_vec_t v [8];
    logic [31:0] bc0, mc0;
    v[0] = '{1, 0, 0, 1, 0, 32'h100, 32'h80,  1, 32'h80};
    v[1] = '{1, 0, 0, 0, 1, 32'h100, 32'h80,  1, 32'h104};
    v[2] = '{1, 0, 0, 1, 1, 32'h100, 32'h80,  0, 32'h0};
    v[3] = '{0, 0, 0, 1, 1, 32'h100, 32'h80,  1, 32'h104};
    v[4] = '{0, 1, 1, 1, 0, 32'h200, 32'h400, 1, 32'h400};
    v[5] = '{0, 1, 1, 1, 1, 32'h200, 32'h400, 1, 32'h400};
    v[6] = '{0, 1, 0, 1, 1, 32'h300, 32'h340, 0, 32'h0};
    v[7] = '{0, 0, 0, 0, 0, 32'h100, 32'h80,  0, 32'h0};
    bc0 = exp_bc; mc0 = exp_mc;
    stallE_i = 1;
    for (int i = 0; i < 8; i++) begin
      set_e(v[i].br, v[i].jmp, v[i].jalr, v[i].tk, v[i].pt, v[i].pc, v[i].tgt);
      #1;
      checks++;
      if (mispredictE_o !== v[i].mis || recoverPCE_o !== v[i].rec) begin
        errors++;
        $display("FAIL mis_vec%0d got %0b/%h exp %0b/%h", i, mispredictE_o, recoverPCE_o, v[i].mis, v[i].rec);
      end
      tick();
    end
    idle_e(); #1;
    checks++;
`ifdef BPRED_STATS_EN
    if (branchCount_o !== bc0 || mispredictCount_o !== mc0) begin
      errors++; $display("FAIL mis_stall_counts got %0d/%0d exp %0d/%0d", branchCount_o, mispredictCount_o, bc0, mc0);
    end
`else
    if (branchCount_o !== 32'd0 || mispredictCount_o !== 32'd0) begin
      errors++; $display("FAIL mis_stall_counts got %0d/%0d exp 0/0", branchCount_o, mispredictCount_o);
    end
`endif
  endtask

  task automatic test_aliasing_jalr();
    set_e(1, 0, 0, 1, 1, 32'h100, 32'h80);  tick();
    set_e(1, 0, 0, 1, 0, 32'h200, 32'h240); tick();
    idle_e();
    lookup(32'h100);
    checks++;
    if (predictTakenF_o !== 1'b0 || predictTargetF_o !== 32'h0) begin
      errors++; $display("FAIL alias_old got %0b/%h exp 0/0", predictTakenF_o, predictTargetF_o);
    end
    lookup(32'h200);
    checks++;
    if (predictTakenF_o !== 1'b1 || predictTargetF_o !== 32'h240) begin
      errors++; $display("FAIL alias_new got %0b/%h exp 1/00000240", predictTakenF_o, predictTargetF_o);
    end
    set_e(0, 1, 1, 1, 0, 32'h200, 32'h500);
    #1;
    checks++;
    if (mispredictE_o !== 1'b1 || recoverPCE_o !== 32'h500) begin
      errors++; $display("FAIL jalr_mis got %0b/%h exp 1/00000500", mispredictE_o, recoverPCE_o);
    end
    tick(); idle_e(); #1;
    checks++;
    if (predictTakenF_o !== 1'b0) begin errors++; $display("FAIL jalr_inval got %0b exp 0", predictTakenF_o); end
    set_e(0, 1, 1, 1, 0, 32'h600, 32'h500); tick(); idle_e();
    lookup(32'h600);
    checks++;
    if (predictTakenF_o !== 1'b0) begin errors++; $display("FAIL jalr_noinstall got %0b exp 0", predictTakenF_o); end
    // JAL installs strongly taken: one not-taken keeps it predicted taken.
    set_e(0, 1, 0, 1, 0, 32'h300, 32'h340); tick();
    set_e(1, 0, 0, 0, 1, 32'h300, 32'h340); tick(); idle_e();
    lookup(32'h300);
    checks++;
    if (predictTakenF_o !== 1'b1 || predictTargetF_o !== 32'h340) begin
      errors++; $display("FAIL jal_strong got %0b/%h exp 1/00000340", predictTakenF_o, predictTargetF_o);
    end
    set_e(1, 0, 0, 0, 1, 32'h300, 32'h340); tick(); idle_e(); #1;
    checks++;
    if (predictTakenF_o !== 1'b0) begin errors++; $display("FAIL jal_weaken got %0b exp 0", predictTakenF_o); end
  endtask

  task automatic test_stall();
    logic [31:0] bc0;
    bc0 = exp_bc;
    lookup(32'h104);
    set_e(1, 0, 0, 1, 0, 32'h104, 32'h1F0);
    stallE_i = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (predictTakenF_o !== 1'b0) begin errors++; $display("FAIL stall_hold%0d got %0b exp 0", i, predictTakenF_o); end
    end
    stallE_i = 0;
    tick(); idle_e(); tick();
    checks++;
    if (predictTakenF_o !== 1'b1 || predictTargetF_o !== 32'h1F0) begin
      errors++; $display("FAIL stall_install got %0b/%h exp 1/000001f0", predictTakenF_o, predictTargetF_o);
    end
    checks++;
`ifdef BPRED_STATS_EN
    if (branchCount_o !== bc0 + 32'd1 || branchCount_o !== exp_bc) begin
      errors++; $display("FAIL stall_count got %0d exp %0d", branchCount_o, bc0 + 32'd1);
    end
`else
    if (branchCount_o !== 32'd0) begin errors++; $display("FAIL stall_count got %0d exp 0", branchCount_o); end
`endif
  endtask

  task automatic test_same_cycle();
    lookup(32'h104);
    set_e(1, 0, 0, 0, 1, 32'h104, 32'h1F0);
    #1;
    checks++;
    if (predictTakenF_o !== 1'b1 || predictTargetF_o !== 32'h1F0) begin
      errors++; $display("FAIL same_old got %0b/%h exp 1/000001f0", predictTakenF_o, predictTargetF_o);
    end
    tick(); idle_e(); #1;
    checks++;
    if (predictTakenF_o !== 1'b0) begin errors++; $display("FAIL same_new got %0b exp 0", predictTakenF_o); end
    checks++;
`ifdef BPRED_STATS_EN
    if (branchCount_o !== exp_bc || mispredictCount_o !== exp_mc) begin
      errors++; $display("FAIL stats_total got %0d/%0d exp %0d/%0d", branchCount_o, mispredictCount_o, exp_bc, exp_mc);
    end
`else
    if (branchCount_o !== 32'd0 || mispredictCount_o !== 32'd0) begin
      errors++; $display("FAIL stats_total got %0d/%0d exp 0/0", branchCount_o, mispredictCount_o);
    end
`endif
  endtask

  task automatic test_reset_midstream();
    set_e(0, 1, 0, 1, 0, 32'h10C, 32'h500); tick(); idle_e();
    lookup(32'h10C);
    checks++;
    if (predictTakenF_o !== 1'b1 || predictTargetF_o !== 32'h500) begin
      errors++; $display("FAIL rstmid_pre got %0b/%h exp 1/00000500", predictTakenF_o, predictTargetF_o);
    end
    rst_i = 1;
    set_e(1, 0, 0, 1, 0, 32'h108, 32'h180);
    tick();
    rst_i = 0; idle_e(); #1;
    checks++;
    if (predictTakenF_o !== 1'b0) begin errors++; $display("FAIL rstmid_clear got %0b exp 0", predictTakenF_o); end
    lookup(32'h108);
    checks++;
    if (predictTakenF_o !== 1'b0 || predictTargetF_o !== 32'h0) begin
      errors++; $display("FAIL rstmid_discard got %0b/%h exp 0/0", predictTakenF_o, predictTargetF_o);
    end
    checks++;
    if (branchCount_o !== 32'd0 || mispredictCount_o !== 32'd0) begin
      errors++; $display("FAIL rstmid_counts got %0d/%0d exp 0/0", branchCount_o, mispredictCount_o);
    end
  endtask

  initial begin
    rst_i = 1; PCF_i = '0; idle_e();
    test_reset();
    test_branch_training();
    test_mispredict();
    test_aliasing_jalr();
    test_stall();
    test_same_cycle();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
